sram_frame_ctrl: RTL and testbench
==================================

# sram_frame_ctrl

Frame-level SRAM control generator sitting directly downstream of the pixel counter. It sequences a full N×M byte frame either from the PRNG pixel source into the external asynchronous SRAM (write pass) or out of the SRAM towards the VGA pixel path (read pass). It owns the counter's reset and active-low enable, converts the counter's (n, m) position into a linear SRAM address, and drives the SRAM strobes.

## Interface
- N, 640: bytes per row; must equal the counter's N
- M, 480: rows per frame; must equal the counter's M
- CNT_WIDTH, 10: width of counter inputs
- ADDR_WIDTH, 19: SRAM address width; N*M ≤ 2^ADDR_WIDTH
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous active-low reset
- i_start  in  1  start-frame pulse, sampled only in IDLE
- i_mode  in  1  0 = write pass, 1 = read pass; sampled with i_start
- i_count_n  in  CNT_WIDTH  counter horizontal position
- i_count_m  in  CNT_WIDTH  counter vertical position
- i_prng_data  in  8  pixel byte from PRNG
- i_sram_rdata  in  8  SRAM data bus input
- o_cnt_rst  out  1  active-low counter reset (registered)
- o_cnt_en  out  1  active-low counter advance enable
- o_prng_en  out  1  PRNG advance strobe
- o_addr  out  ADDR_WIDTH  SRAM address
- o_sram_wdata  out  8  SRAM write data
- o_sram_wdata_oe  out  1  tri-state drive enable for SRAM data bus
- o_ce_n, o_we_n, o_oe_n  out  1 each  SRAM chip/write/output enables, active low
- o_pixel  out  8  read-back byte
- o_pixel_valid  out  1  o_pixel valid, one-cycle pulse
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle end-of-frame pulse

## Operation
- All outputs registered; values below are those present while FSM is in the named state.
- IDLE: all strobes inactive. i_start=1 → CLR; i_mode latched.
- CLR (1 cycle): o_cnt_rst=0, clearing counter to (0,0). → WR_SETUP or RD_SETUP.
- WR_SETUP: o_addr = i_count_m*N + i_count_n (truncated to ADDR_WIDTH), o_sram_wdata = i_prng_data, o_sram_wdata_oe=1, o_ce_n=0, o_we_n=1.
- WR_PULSE: o_we_n=0; addr/data stable.
- WR_HOLD: o_we_n=1, addr/data stable, o_cnt_en=0, o_prng_en=1 (single cycle each).
- Last-byte detection in WR_HOLD/RD_SAMPLE: i_count_n==N-1 and i_count_m==M-1 → DONE, else → *_SETUP.
- RD_SETUP: o_addr computed as above, o_ce_n=0, o_oe_n=0, o_sram_wdata_oe=0.
- RD_SAMPLE: o_oe_n=0, o_pixel ← i_sram_rdata, o_pixel_valid=1, o_cnt_en=0.
- DONE (1 cycle): strobes inactive, o_done=1 → IDLE.
- i_start ignored while o_busy=1; no abort path other than reset.
- o_we_n and o_oe_n never low in the same cycle; o_sram_wdata_oe=1 only in WR_* states.

## Timing
- Reset values: o_cnt_rst=1, o_cnt_en=1, o_prng_en=0, o_addr=0, o_sram_wdata=0, o_sram_wdata_oe=0, o_ce_n=1, o_we_n=1, o_oe_n=1, o_pixel=0, o_pixel_valid=0, o_busy=0, o_done=0; FSM=IDLE.
- i_start sampled at edge k → o_busy=1, o_cnt_rst=0 in cycle k+1.
- Write byte: 3 cycles (2 without hold); read byte: 2 cycles.
- Busy cycles per frame: 2 + N*M*bytecycles (CLR + DONE).
- Counter advances at edge closing the o_cnt_en=0 cycle; next SETUP sees new position.
- Reset mid-frame: all outputs immediately to reset values; SRAM contents undefined for partial byte.

## Configuration
- SRAM_CTRL_WR_HOLD_EN defined: WR_HOLD state present as above (3-cycle write, data held one cycle after we_n rises).
- Undefined: WR_HOLD removed; WR_PULSE asserts o_cnt_en=0 and o_prng_en=1 and performs last-byte check; we_n rises with address change (2-cycle write).

## Test plan
- N=4, M=2, hold enabled, write pass: 8 we_n pulses at addresses 0..7 carrying PRNG bytes in order; o_done at busy cycle 26; busy 26 cycles.
- Same, macro undefined: 8 writes, busy 18 cycles, we_n low exactly one cycle per byte.
- Read pass after write: o_pixel_valid 8 times, o_pixel equals bytes written at addr 0..7; busy 18 cycles; o_we_n stays 1.
- i_start pulsed while busy: ignored, frame length and addresses unchanged.
- Reset asserted at byte 3 of write: all outputs to reset values same cycle; new i_start restarts from address 0 with o_cnt_rst pulse.
- N=640, M=480: final write address 307199, no address ≥ 307200 issued.

Source files
------------

// File: rtl/sram_frame_ctrl.sv
// rtl/sram_frame_ctrl.sv - Frame sequencer moving N*M bytes between PRNG, async SRAM and pixel path
// Define SRAM_CTRL_WR_HOLD_EN to add a data-hold cycle after every write strobe.
module sram_frame_ctrl #(
    parameter int N          = 640,
    parameter int M          = 480,
    parameter int CNT_WIDTH  = 10,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_mode,
    input  logic [CNT_WIDTH-1:0]  i_count_n,
    input  logic [CNT_WIDTH-1:0]  i_count_m,
    input  logic [7:0]            i_prng_data,
    input  logic [7:0]            i_sram_rdata,
    output logic                  o_cnt_rst,
    output logic                  o_cnt_en,
    output logic                  o_prng_en,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [7:0]            o_sram_wdata,
    output logic                  o_sram_wdata_oe,
    output logic                  o_ce_n,
    output logic                  o_we_n,
    output logic                  o_oe_n,
    output logic [7:0]            o_pixel,
    output logic                  o_pixel_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WR_SETUP,
        S_WR_PULSE,
`ifdef SRAM_CTRL_WR_HOLD_EN
        S_WR_HOLD,
`endif
        S_RD_SETUP,
        S_RD_SAMPLE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  cnt_rst_q, cnt_rst_d;
    logic                  cnt_en_q, cnt_en_d;
    logic                  prng_en_q, prng_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  wdata_oe_q, wdata_oe_d;
    logic                  ce_n_q, ce_n_d;
    logic                  we_n_q, we_n_d;
    logic                  oe_n_q, oe_n_d;
    logic [7:0]            pixel_q, pixel_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] pos_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  last_byte;
    logic                  in_wr;
    logic                  in_rd;
    logic                  advance;

    // The counter steps at the edge that leaves the advance cycle, so the address
    // for the next SETUP is the linear position plus one, registered at that same edge.
    assign pos_addr  = ADDR_WIDTH'(i_count_m) * ADDR_WIDTH'(N) + ADDR_WIDTH'(i_count_n);
    assign next_addr = pos_addr + 1'b1;
    assign last_byte = (i_count_n == CNT_WIDTH'(N - 1)) && (i_count_m == CNT_WIDTH'(M - 1));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pixel_d = pixel_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CLR;
                    mode_d  = i_mode;
                end
            end
            S_CLR: begin
                state_d = mode_q ? S_RD_SETUP : S_WR_SETUP;
                addr_d  = '0;
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                wdata_d = i_prng_data;
            end
`ifdef SRAM_CTRL_WR_HOLD_EN
            S_WR_PULSE: begin
                state_d = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                if (last_byte) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR_SETUP;
                    addr_d  = next_addr;
                end
            end
`else
            S_WR_PULSE: begin
                if (last_byte) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR_SETUP;
                    addr_d  = next_addr;
                end
            end
`endif
            S_RD_SETUP: begin
                state_d = S_RD_SAMPLE;
                pixel_d = i_sram_rdata;
            end
            S_RD_SAMPLE: begin
                if (last_byte) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_SETUP;
                    addr_d  = next_addr;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so each registered output lines up with its state.
    always_comb begin
`ifdef SRAM_CTRL_WR_HOLD_EN
        in_wr   = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
        advance = (state_d == S_WR_HOLD) || (state_d == S_RD_SAMPLE);
        prng_en_d = (state_d == S_WR_HOLD);
`else
        in_wr   = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE);
        advance = (state_d == S_WR_PULSE) || (state_d == S_RD_SAMPLE);
        prng_en_d = (state_d == S_WR_PULSE);
`endif
        in_rd         = (state_d == S_RD_SETUP) || (state_d == S_RD_SAMPLE);
        cnt_rst_d     = (state_d != S_CLR);
        cnt_en_d      = !advance;
        wdata_oe_d    = in_wr;
        ce_n_d        = !(in_wr || in_rd);
        we_n_d        = (state_d != S_WR_PULSE);
        oe_n_d        = !in_rd;
        pixel_valid_d = (state_d == S_RD_SAMPLE);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            cnt_rst_q     <= 1'b1;
            cnt_en_q      <= 1'b1;
            prng_en_q     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wdata_oe_q    <= 1'b0;
            ce_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_rst_q     <= cnt_rst_d;
            cnt_en_q      <= cnt_en_d;
            prng_en_q     <= prng_en_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wdata_oe_q    <= wdata_oe_d;
            ce_n_q        <= ce_n_d;
            we_n_q        <= we_n_d;
            oe_n_q        <= oe_n_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign o_cnt_rst       = cnt_rst_q;
    assign o_cnt_en        = cnt_en_q;
    assign o_prng_en       = prng_en_q;
    assign o_addr          = addr_q;
    assign o_sram_wdata    = wdata_q;
    assign o_sram_wdata_oe = wdata_oe_q;
    assign o_ce_n          = ce_n_q;
    assign o_we_n          = we_n_q;
    assign o_oe_n          = oe_n_q;
    assign o_pixel         = pixel_q;
    assign o_pixel_valid   = pixel_valid_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_sram_frame_ctrl.sv
// tb/tb_sram_frame_ctrl.sv - Scoreboard bench for sram_frame_ctrl with counter, PRNG and SRAM models
module tb_sram_frame_ctrl;
    localparam int N  = 4;
    localparam int M  = 2;
    localparam int CW = 10;
    localparam int AW = 19;
    localparam int NB = N * M;
`ifdef SRAM_CTRL_WR_HOLD_EN
    localparam int WR_CYC = 3;
`else
    localparam int WR_CYC = 2;
`endif
    localparam int RD_CYC = 2;
    localparam logic [44:0] RST_VEC = {1'b1, 1'b1, 1'b0, 19'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } xact_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] cnt_n = 10'd2;
    logic [CW-1:0] cnt_m = 10'd1;
    logic [7:0]    prng_data;
    logic [7:0]    sram_rdata;
    logic          o_cnt_rst, o_cnt_en, o_prng_en, o_sram_wdata_oe;
    logic [AW-1:0] o_addr;
    logic [7:0]    o_sram_wdata, o_pixel;
    logic          o_ce_n, o_we_n, o_oe_n, o_pixel_valid, o_busy, o_done;

    logic          start2 = 1'b0;
    logic [CW-1:0] c2_n = '0;
    logic [CW-1:0] c2_m = '0;
    logic          b_cnt_rst, b_cnt_en, b_prng_en, b_wdata_oe;
    logic [AW-1:0] b_addr;
    logic [7:0]    b_wdata, b_pixel;
    logic          b_ce_n, b_we_n, b_oe_n, b_pixel_valid, b_busy, b_done;

    logic [7:0] prng_tab [0:1023];
    logic [9:0] prng_idx = '0;
    logic [7:0] sram [0:NB-1];
    logic [7:0] ref_mem [0:NB-1];
    xact_t      exp_wr[$];
    xact_t      exp_rd[$];
    xact_t      mx;

    int vectors = 0;
    int errors = 0;
    int busy_tot = 0, we_tot = 0, rst_tot = 0, done_tot = 0, rst_at = 0, done_at = 0;
    int wr2 = 0, hi2 = 0, done2 = 0;
    logic [AW-1:0] last2 = '0;

    always #5 clk = ~clk;

    sram_frame_ctrl #(.N(N), .M(M), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_mode(mode),
        .i_count_n(cnt_n), .i_count_m(cnt_m), .i_prng_data(prng_data), .i_sram_rdata(sram_rdata),
        .o_cnt_rst(o_cnt_rst), .o_cnt_en(o_cnt_en), .o_prng_en(o_prng_en), .o_addr(o_addr),
        .o_sram_wdata(o_sram_wdata), .o_sram_wdata_oe(o_sram_wdata_oe),
        .o_ce_n(o_ce_n), .o_we_n(o_we_n), .o_oe_n(o_oe_n),
        .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid), .o_busy(o_busy), .o_done(o_done)
    );

    sram_frame_ctrl #(.N(640), .M(480), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut_vga (
        .i_clk(clk), .i_rst(rst_n), .i_start(start2), .i_mode(1'b0),
        .i_count_n(c2_n), .i_count_m(c2_m), .i_prng_data(8'h5A), .i_sram_rdata(8'h00),
        .o_cnt_rst(b_cnt_rst), .o_cnt_en(b_cnt_en), .o_prng_en(b_prng_en), .o_addr(b_addr),
        .o_sram_wdata(b_wdata), .o_sram_wdata_oe(b_wdata_oe),
        .o_ce_n(b_ce_n), .o_we_n(b_we_n), .o_oe_n(b_oe_n),
        .o_pixel(b_pixel), .o_pixel_valid(b_pixel_valid), .o_busy(b_busy), .o_done(b_done)
    );

    // Pixel counter: synchronous clear on cnt_rst low, step on cnt_en low, raster wrap.
    always @(posedge clk) begin
        if (!o_cnt_rst) begin
            cnt_n <= '0;
            cnt_m <= '0;
        end else if (!o_cnt_en) begin
            if (cnt_n == CW'(N - 1)) begin
                cnt_n <= '0;
                cnt_m <= (cnt_m == CW'(M - 1)) ? '0 : cnt_m + 1'b1;
            end else begin
                cnt_n <= cnt_n + 1'b1;
            end
        end
        if (o_prng_en) prng_idx <= prng_idx + 1'b1;
    end

    // The VGA-size counter is fast-forwarded to the last row on clear to reach the frame end quickly.
    always @(posedge clk) begin
        if (!b_cnt_rst) begin
            c2_n <= 10'd636;
            c2_m <= 10'd479;
        end else if (!b_cnt_en) begin
            if (c2_n == 10'd639) begin
                c2_n <= '0;
                c2_m <= (c2_m == 10'd479) ? '0 : c2_m + 1'b1;
            end else begin
                c2_n <= c2_n + 1'b1;
            end
        end
    end

    assign prng_data  = prng_tab[prng_idx];
    assign sram_rdata = (!o_ce_n && !o_oe_n && o_addr < AW'(NB)) ? sram[o_addr[2:0]] : 8'h00;

    always @(negedge clk) begin
        if (!o_ce_n && !o_we_n && o_sram_wdata_oe && o_addr < AW'(NB)) sram[o_addr[2:0]] <= o_sram_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_busy) begin
            busy_tot++;
            check("bus_exclusive", {62'd0, !o_we_n && !o_oe_n, o_sram_wdata_oe && !o_oe_n}, 64'd0);
        end
        if (!o_cnt_rst) begin
            rst_tot++;
            rst_at = busy_tot;
        end
        if (o_done) begin
            done_tot++;
            done_at = busy_tot;
        end
        if (!o_we_n && !o_ce_n) begin
            we_tot++;
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 64'(o_addr), 64'hFFFF_FFFF);
            end else begin
                mx = exp_wr.pop_front();
                check("write_addr", 64'(o_addr), 64'(mx.addr));
                check("write_data", 64'(o_sram_wdata), 64'(mx.data));
            end
        end
        if (o_pixel_valid) begin
            if (exp_rd.size() == 0) begin
                check("unexpected_pixel", 64'(o_pixel), 64'hFFFF_FFFF);
            end else begin
                mx = exp_rd.pop_front();
                check("read_addr", 64'(o_addr), 64'(mx.addr));
                check("read_pixel", 64'(o_pixel), 64'(mx.data));
            end
        end
        if (!b_we_n && !b_ce_n) begin
            wr2++;
            last2 = b_addr;
            if (b_addr >= 19'd307200) hi2++;
        end
        if (b_done) done2++;
    end

    task automatic push_frame(input bit rd);
        xact_t x;
        for (int i = 0; i < NB; i++) begin
            x.addr = AW'(i);
            if (rd) begin
                x.data = ref_mem[i];
                exp_rd.push_back(x);
            end else begin
                x.data = prng_tab[prng_idx + 10'(i)];
                ref_mem[i] = x.data;
                exp_wr.push_back(x);
            end
        end
    endtask

    task automatic pulse_start(input bit rd);
        @(posedge clk);
        #1 start = 1'b1;
        mode = rd;
        @(posedge clk);
        #1 start = 1'b0;
        mode = ~rd;
    endtask

    task automatic run_frame(input bit rd, input bit poke);
        int b0, w0, r0, d0, t, cyc;
        cyc = 2 + NB * (rd ? RD_CYC : WR_CYC);
        push_frame(rd);
        b0 = busy_tot; w0 = we_tot; r0 = rst_tot; d0 = done_tot;
        pulse_start(rd);
        if (poke) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        t = 0;
        while (done_tot == d0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("done_count", 64'(done_tot - d0), 64'd1);
        check("busy_cycles", 64'(busy_tot - b0), 64'(cyc));
        check("done_position", 64'(done_at - b0), 64'(cyc));
        check("cnt_rst_pulses", 64'(rst_tot - r0), 64'd1);
        check("cnt_rst_position", 64'(rst_at - b0), 64'd1);
        check("we_low_cycles", 64'(we_tot - w0), 64'(rd ? 0 : NB));
        check("queue_drained", 64'(exp_wr.size() + exp_rd.size()), 64'd0);
        check("idle_after", 64'(o_busy), 64'd0);
        exp_wr.delete();
        exp_rd.delete();
    endtask

    initial begin
        int w0, t;
        for (int i = 0; i < 1024; i++) prng_tab[i] = 8'($urandom);
        for (int i = 0; i < NB; i++) sram[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 64'({o_cnt_rst, o_cnt_en, o_prng_en, o_addr, o_sram_wdata, o_sram_wdata_oe,
                                       o_ce_n, o_we_n, o_oe_n, o_pixel, o_pixel_valid, o_busy, o_done}), 64'(RST_VEC));
        @(negedge clk) rst_n = 1'b1;

        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b1);

        // Abort a write after its third byte with an asynchronous reset.
        push_frame(1'b0);
        w0 = we_tot;
        pulse_start(1'b0);
        t = 0;
        while (we_tot - w0 < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("abort_reached", 64'(we_tot - w0), 64'd3);
        #2 rst_n = 1'b0;
        #1 check("midframe_reset", 64'({o_cnt_rst, o_cnt_en, o_prng_en, o_addr, o_sram_wdata, o_sram_wdata_oe,
                                        o_ce_n, o_we_n, o_oe_n, o_pixel, o_pixel_valid, o_busy, o_done}), 64'(RST_VEC));
        exp_wr.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);

        @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        t = 0;
        while (done2 == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("vga_done", 64'(done2), 64'd1);
        check("vga_writes", 64'(wr2), 64'd4);
        check("vga_last_addr", 64'(last2), 64'd307199);
        check("vga_addr_overflow", 64'(hi2), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
